// File: rtl/subtractor_pkg.sv
// Shared definitions for the subtractor family: FSM encoding and
// single-bit full-subtractor equations.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Difference bit of x - y - bin.
    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Borrow generated by x - y - bin.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = x - y - bin, with borrow-out.
module full_subtractor
    import subtractor_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = fs_diff(x, y, bin);
    assign bout = fs_borrow(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor d = a - b - bin, LSB first, one bit per clock,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
);

    // A 1-bit counter is kept even for N=1 so the compare stays well formed.
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_e          state_q, state_d;
    logic [N-1:0]    ra_q, ra_d;
    logic [N-1:0]    rb_q, rb_d;
    logic            borrow_q, borrow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    d_q, d_d;
    logic            bout_q, bout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            bit_diff;
    logic            bit_borrow;

    full_subtractor u_fs (
        .x    (ra_q[0]),
        .y    (rb_q[0]),
        .bin  (borrow_q),
        .diff (bit_diff),
        .bout (bit_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d     = a;
                    rb_d     = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    d_d      = '0;
                    bout_d   = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB lands in d[0] after N shifts.
                d_d      = (d_q >> 1) | (N'(bit_diff) << (N - 1));
                ra_d     = ra_q >> 1;
                rb_d     = rb_q >> 1;
                borrow_d = bit_borrow;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    bout_d  = bit_borrow;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at N=4, N=8 and N=1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st4, bi4, busy4, done4, bo4;
    logic [3:0] a4, b4, d4;
    logic       st8, bi8, busy8, done8, bo8;
    logic [7:0] a8, b8, d8;
    logic       st1, bi1, busy1, done1, bo1;
    logic [0:0] a1, b1, d1;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .bin(bi4),
        .busy(busy4), .done(done4), .d(d4), .bout(bo4)
    );
    serial_subtractor #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .bin(bi8),
        .busy(busy8), .done(done8), .d(d8), .bout(bo8)
    );
    serial_subtractor #(.N(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bi1),
        .busy(busy1), .done(done1), .d(d1), .bout(bo1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input logic [7:0] av,
                         input logic [7:0] bv, input logic bi);
        case (w)
            4: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; bi4 = bi; end
            8: begin st8 = s; a8 = av;      b8 = bv;      bi8 = bi; end
            default: begin st1 = s; a1 = av[0:0]; b1 = bv[0:0]; bi1 = bi; end
        endcase
    endtask

    function automatic logic [7:0] get_d(input int w);
        case (w)
            4: return {4'b0, d4};
            8: return d8;
            default: return {7'b0, d1};
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4: return done4;
            8: return done8;
            default: return done1;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4: return busy4;
            8: return busy8;
            default: return busy1;
        endcase
    endfunction

    function automatic logic get_bout(input int w);
        case (w)
            4: return bo4;
            8: return bo8;
            default: return bo1;
        endcase
    endfunction

    // One full operation: launch, scramble inputs, wait for done, check result and release.
    task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input logic [7:0] ed, input logic eb,
                         input string tag);
        int cyc;
        drive(w, 1'b1, av, bv, bi);
        tick();
        chk({tag, "_busy_rise"}, 32'(get_busy(w)), 32'd1);
        chk({tag, "_d_clear"}, 32'(get_d(w)), 32'd0);
        drive(w, 1'b0, ~av, ~bv, ~bi);
        cyc = 0;
        while (get_done(w) !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(w));
        chk({tag, "_d"}, 32'(get_d(w)), 32'(ed));
        chk({tag, "_bout"}, 32'(get_bout(w)), 32'(eb));
        tick();
        chk({tag, "_done_fall"}, 32'(get_done(w)), 32'd0);
        chk({tag, "_busy_fall"}, 32'(get_busy(w)), 32'd0);
        chk({tag, "_d_hold"}, 32'(get_d(w)), 32'(ed));
    endtask

    task automatic rand_op(input int w, input string tag);
        logic [7:0] av, bv, ed;
        logic       bi, eb;
        int         mask;
        mask = (1 << w) - 1;
        av = 8'($urandom() & mask);
        bv = 8'($urandom() & mask);
        bi = 1'($urandom_range(1, 0));
        ed = 8'((int'(av) - int'(bv) - int'(bi)) & mask);
        eb = (int'(av) < int'(bv) + int'(bi));
        do_op(w, av, bv, bi, ed, eb, tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_d4", 32'(d4), 32'd0);
        chk("rst_bout4", 32'(bo4), 32'd0);
        chk("rst_d8", 32'(d8), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(4, 8'h07, 8'h05, 1'b0, 8'h02, 1'b0, "n4_7m5");
        do_op(4, 8'h05, 8'h07, 1'b0, 8'h0E, 1'b1, "n4_5m7");
        do_op(4, 8'h00, 8'h00, 1'b1, 8'h0F, 1'b1, "n4_0m0b");
        do_op(4, 8'h0F, 8'h0F, 1'b0, 8'h00, 1'b0, "n4_fmf");
        do_op(8, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "n8_0m1");
        do_op(8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "n8_fmfb");
        do_op(8, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, "n8_80m7f");
        do_op(1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1, "n1_0m0b");
        do_op(1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, "n1_1m0");

        // start held high: a new operation is accepted only from IDLE, every N+2 clocks
        drive(4, 1'b1, 8'h0A, 8'h05, 1'b0);
        tick();
        for (int k = 1; k <= 17; k++) begin
            if (k % 6 == 1) drive(4, 1'b1, 8'h0F, 8'h00, 1'b1);
            if (k % 6 == 4) drive(4, 1'b1, 8'h0A, 8'h05, 1'b0);
            tick();
            chk("held_done", 32'(done4), 32'(k % 6 == 4));
            chk("held_busy", 32'(busy4), 32'(k % 6 != 5));
            if (k % 6 == 4) begin
                chk("held_d", 32'(d4), 32'h5);
                chk("held_bout", 32'(bo4), 32'd0);
            end
        end
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("held_idle", 32'(busy4), 32'd0);

        // asynchronous reset in the middle of an operation
        drive(4, 1'b1, 8'h0F, 8'h00, 1'b0);
        tick();
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("pre_rst_d", 32'(d4), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_done", 32'(done4), 32'd0);
        chk("arst_d", 32'(d4), 32'd0);
        chk("arst_bout", 32'(bo4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy4), 32'd0);
        do_op(4, 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, "n4_after_rst");

        for (int i = 0; i < 150; i++) rand_op(4, "rnd4");
        for (int i = 0; i < 150; i++) rand_op(8, "rnd8");
        for (int i = 0; i < 20; i++) rand_op(1, "rnd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
